// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Write side of the CPU register file. Decodes the write-back
//                register number into a one-hot enable and stores write-back
//                data into one of 31 architectural registers. Register 0 is
//                hard-wired to zero. All registers are presented in parallel
//                to the rs/rt read-port selectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regwrite,
  input  logic [4:0]       writeaddress,
  input  logic [WIDTH-1:0] writedata,
  output logic [31:0]      wrenable,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic [WIDTH-1:0] reg4,
  output logic [WIDTH-1:0] reg5,
  output logic [WIDTH-1:0] reg6,
  output logic [WIDTH-1:0] reg7,
  output logic [WIDTH-1:0] reg8,
  output logic [WIDTH-1:0] reg9,
  output logic [WIDTH-1:0] reg10,
  output logic [WIDTH-1:0] reg11,
  output logic [WIDTH-1:0] reg12,
  output logic [WIDTH-1:0] reg13,
  output logic [WIDTH-1:0] reg14,
  output logic [WIDTH-1:0] reg15,
  output logic [WIDTH-1:0] reg16,
  output logic [WIDTH-1:0] reg17,
  output logic [WIDTH-1:0] reg18,
  output logic [WIDTH-1:0] reg19,
  output logic [WIDTH-1:0] reg20,
  output logic [WIDTH-1:0] reg21,
  output logic [WIDTH-1:0] reg22,
  output logic [WIDTH-1:0] reg23,
  output logic [WIDTH-1:0] reg24,
  output logic [WIDTH-1:0] reg25,
  output logic [WIDTH-1:0] reg26,
  output logic [WIDTH-1:0] reg27,
  output logic [WIDTH-1:0] reg28,
  output logic [WIDTH-1:0] reg29,
  output logic [WIDTH-1:0] reg30,
  output logic [WIDTH-1:0] reg31
);

  // Storage for registers 1..31; register 0 has no storage element.
  logic [WIDTH-1:0] r_regs [1:31];

  // Decode the write address into a one-hot enable. The address is only
  // examined when regwrite is high, so an unknown address with regwrite low
  // still yields an all-zero enable. Bit 0 never asserts.
  always_comb begin
    wrenable = '0;
    if (regwrite) begin
      for (int i = 1; i < 32; i++) begin
        wrenable[i] = (writeaddress == i[4:0]);
      end
    end
  end

  // One register per architectural slot; reset wins over a coincident write.
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      // Load full-width write-back data when this slot is enabled, else hold.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_regs[gi] <= '0;
        end else if (wrenable[gi]) begin
          r_regs[gi] <= writedata;
        end
      end
    end
  endgenerate

  // Parallel register outputs for the read-port selectors.
  assign reg0  = '0;
  assign reg1  = r_regs[1];
  assign reg2  = r_regs[2];
  assign reg3  = r_regs[3];
  assign reg4  = r_regs[4];
  assign reg5  = r_regs[5];
  assign reg6  = r_regs[6];
  assign reg7  = r_regs[7];
  assign reg8  = r_regs[8];
  assign reg9  = r_regs[9];
  assign reg10 = r_regs[10];
  assign reg11 = r_regs[11];
  assign reg12 = r_regs[12];
  assign reg13 = r_regs[13];
  assign reg14 = r_regs[14];
  assign reg15 = r_regs[15];
  assign reg16 = r_regs[16];
  assign reg17 = r_regs[17];
  assign reg18 = r_regs[18];
  assign reg19 = r_regs[19];
  assign reg20 = r_regs[20];
  assign reg21 = r_regs[21];
  assign reg22 = r_regs[22];
  assign reg23 = r_regs[23];
  assign reg24 = r_regs[24];
  assign reg25 = r_regs[25];
  assign reg26 = r_regs[26];
  assign reg27 = r_regs[27];
  assign reg28 = r_regs[28];
  assign reg29 = r_regs[29];
  assign reg30 = r_regs[30];
  assign reg31 = r_regs[31];

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
# regfile_writeback

Write side of the CPU register file: decodes the 5-bit write-back register number into a one-hot enable, and stores the write-back value into one of 32 architectural registers on the clock edge. All 32 register values are driven out in parallel and feed the two `mux32to1by32` read-port selectors (rs and rt). Register 0 is hard-wired to zero. The write-back address comes from `mux3to1by5` (rd/rt/31) and the data comes from the write-back datapath.

## Interface
- `WIDTH`, default 32, data width of each register.
- `clk`, in, 1, single system clock; all state changes on its rising edge.
- `reset`, in, 1, synchronous, active-high; clears all registers.
- `regwrite`, in, 1, write enable for the current cycle.
- `writeaddress`, in, 5, destination register number (0–31).
- `writedata`, in, WIDTH, value to store.
- `wrenable`, out, 32, one-hot decode of `writeaddress` gated by `regwrite`. Bit 0 is always 0. Combinational.
- `reg0` … `reg31`, out, WIDTH each, current register contents. Registered outputs. `reg0` is constant 0.

## Operation
- **Decoder**
  - `wrenable[i]` = `regwrite` && (`writeaddress` == i), for i = 1..31.
  - `wrenable[0]` = 0 unconditionally.
  - With `regwrite` = 0, `wrenable` = 0, whatever the value of `writeaddress` (including X/Z).
- **Storage**
  - 31 WIDTH-bit registers, for i = 1..31. Each loads `writedata` at the rising edge when `wrenable[i]` = 1, and holds otherwise.
  - No partial or byte writes; the full WIDTH bits are written.
  - `reg0` is not a storage element. It is tied to 0.
  - A write to address 0 is accepted silently. No register changes.
- **Reset**
  - At a rising edge with `reset` = 1, all of `reg1`..`reg31` become 0.
  - Reset has priority over a simultaneous write. The write is dropped, not deferred.
  - Reset asserted in the middle of a program clears state at that edge. The first write honoured is the one at the first edge with `reset` = 0.
- **No bypass**: a value written at edge N is visible on `regN` outputs only after edge N. Same-cycle read-after-write sees the old value. Forwarding is not part of this block.
- **No side effects** on registers other than the single addressed one. Any register not written holds its value indefinitely.

## Timing
- Write latency: 1 edge, from `regwrite`/`writeaddress`/`writedata` valid to the `regX` output updated.
- `wrenable` is combinational from `regwrite` and `writeaddress`, with zero cycles of latency.
- Inputs must be stable for setup before the rising edge of `clk`. There is no handshake: one write per cycle maximum, and every cycle may write.
- Back-to-back writes to the same register: the last edge wins. Each intermediate value is visible for exactly one cycle.
- Reset values: `reg0`..`reg31` = 0 after the first reset edge. `wrenable` follows its inputs (0 while `regwrite` = 0).
- Before the first reset, register contents are undefined (X in simulation), except `reg0` = 0.

## Test plan
- **Reset clear**: write 0xDEADBEEF to registers 1..31, then assert `reset` for 1 cycle. Required: all of `reg0`..`reg31` = 0x00000000 after the edge.
- **Decode and write**:
  - Stimulus: `regwrite` = 1, `writeaddress` = 5, `writedata` = 0x12345678.
  - Required before the edge: `wrenable` = 0x00000020.
  - Required after the edge: `reg5` = 0x12345678 and every other register unchanged.
  - Repeat for all 32 addresses with distinct data, then read all of them back.
- **Register zero**: `regwrite` = 1, `writeaddress` = 0, `writedata` = 0xFFFFFFFF. Required: `wrenable` = 0 and `reg0` = 0 after the edge. Registers 1..31 unchanged.
- **Write gating**: `regwrite` = 0, `writeaddress` = 31, `writedata` = 0xAAAA5555. Required: `wrenable` = 0 and `reg31` keeps its previous value. Repeat with `writeaddress` = X; no register changes.
- **Reset vs write collision**:
  - Setup: `reg7` = 0x11111111.
  - Stimulus, same cycle: `reset` = 1, `regwrite` = 1, `writeaddress` = 7, `writedata` = 0x22222222.
  - Required: `reg7` = 0 after the edge, and still 0 on the next cycle with `regwrite` = 0.
- **Back-to-back and read-after-write**:
  - Stimulus: write 0x1 then 0x2 to register 31 on consecutive edges.
  - Required: `reg31` = 0x1 for exactly one cycle, then 0x2.
  - Required: during the cycle of the second write, `reg31` still shows 0x1.
